// File: rtl/div_sequencer.sv
// Sequences one request at a time through an external multi-cycle divider. It bypasses the divider for
// divide-by-zero and aborts on a watchdog timeout. Optional signed operands: define DIV_SIGNED_EN.
module div_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_d,
  input  logic        in_signed,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_d,
  input  logic [63:0] div_r,
  input  logic        div_busy,
  input  logic        div_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_q,
  output logic [31:0] out_rem,
  output logic        out_dz,
  output logic        out_to
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         d_q, d_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [31:0]         quot_q, quot_d;
  logic [31:0]         rem_q, rem_d;
  logic                dz_q, dz_d;
  logic                to_q, to_d;

  // Operands as handed to the divider, and the divider result as presented to the consumer.
  logic [31:0]         a_mag, d_mag;
  logic [31:0]         cap_quot, cap_rem;

`ifdef DIV_SIGNED_EN
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic                a_neg, d_neg;
  logic                unused_ok;

  assign a_neg     = in_signed & in_a[31];
  assign d_neg     = in_signed & in_d[31];
  assign a_mag     = a_neg ? (~in_a + 32'd1) : in_a;
  assign d_mag     = d_neg ? (~in_d + 32'd1) : in_d;
  // -2^31 has no positive magnitude; the unsigned pattern 2^31 divides correctly and wraps back.
  assign cap_quot  = neg_quot_q ? (~div_r[31:0] + 32'd1) : div_r[31:0];
  assign cap_rem   = neg_rem_q ? (~div_r[63:32] + 32'd1) : div_r[63:32];
  assign unused_ok = div_busy;
`else
  logic                unused_ok;

  assign a_mag     = in_a;
  assign d_mag     = in_d;
  assign cap_quot  = div_r[31:0];
  assign cap_rem   = div_r[63:32];
  assign unused_ok = ^{div_busy, in_signed};
`endif

  // NOTE: every output of this block gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    wdog_d  = wdog_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    to_d    = to_q;
`ifdef DIV_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_d == 32'd0) begin
            // The divider is never started; the raw dividend keeps its sign as the remainder.
            quot_d  = 32'hFFFF_FFFF;
            rem_d   = in_a;
            dz_d    = 1'b1;
            to_d    = 1'b0;
            state_d = S_HOLD;
          end else begin
            a_d     = a_mag;
            d_d     = d_mag;
`ifdef DIV_SIGNED_EN
            neg_quot_d = a_neg ^ d_neg;
            neg_rem_d  = a_neg;
`endif
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (div_done) begin
          quot_d  = cap_quot;
          rem_d   = cap_rem;
          dz_d    = 1'b0;
          to_d    = 1'b0;
          state_d = S_HOLD;
        end else if (wdog_d == WDOG_W'(TIMEOUT_CYCLES)) begin
          quot_d  = '0;
          rem_d   = '0;
          dz_d    = 1'b0;
          to_d    = 1'b1;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          dz_d    = 1'b0;
          to_d    = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register is plain state (no memory array), so all of them are cleared on reset.
      state_q <= S_IDLE;
      a_q     <= '0;
      d_q     <= '0;
      wdog_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      to_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      wdog_q  <= wdog_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      to_q    <= to_d;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign div_start = (state_q == S_ISSUE);
  assign div_a     = a_q;
  assign div_d     = d_q;
  assign out_valid = (state_q == S_HOLD);
  assign out_q     = quot_q;
  assign out_rem   = rem_q;
  assign out_dz    = dz_q;
  assign out_to    = to_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: a behavioural divider with programmable latency, plus a result scoreboard.
module tb_div_sequencer;

  localparam int unsigned TO_CYC = 8;

  typedef struct {
    logic [31:0] q;
    logic [31:0] rem;
    logic        dz;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_signed, div_start, div_busy, div_done;
  logic        out_valid, out_ready, out_dz, out_to;
  logic [31:0] in_a, in_d, div_a, div_d, out_q, out_rem;
  logic [63:0] div_r = '0;

  // Behavioural divider: not reset by rst, so a divide in flight keeps running.
  logic        done_m = 1'b0, stray_done = 1'b0, m_busy = 1'b0, m_stale = 1'b0;
  logic        never_done = 1'b0;
  logic [31:0] m_a = '0, m_d = '0;
  int          m_cnt = 0, lat = 0, start_cnt = 0, done_cnt = 0;
  int          checks = 0, errors = 0;
  exp_t        sb[$];

  assign div_done = done_m | stray_done;
  assign div_busy = m_busy;

  always #5 clk = ~clk;

  div_sequencer #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_d(in_d),
    .in_signed(in_signed), .div_start(div_start), .div_a(div_a), .div_d(div_d), .div_r(div_r),
    .div_busy(div_busy), .div_done(div_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_rem(out_rem), .out_dz(out_dz), .out_to(out_to)
  );

  always @(posedge clk) begin
    done_m <= 1'b0;
    if (rst) m_stale <= 1'b1;
    if (div_start) begin
      start_cnt <= start_cnt + 1;
      m_a       <= div_a;
      m_d       <= div_d;
      m_cnt     <= lat;
      m_busy    <= !never_done;
      m_stale   <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        done_m   <= 1'b1;
        div_r    <= {m_a % m_d, m_a / m_d};
        m_busy   <= 1'b0;
        done_cnt <= done_cnt + 1;
        if (!m_stale) begin
          checks++;
          assert (div_a === m_a && div_d === m_d) else begin
            errors++;
            $error("FAIL operands_stable: observed %h/%h expected %h/%h", div_a, div_d, m_a, m_d);
          end
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [31:0] q, input logic [31:0] rem, input logic dz,
                               input logic to);
    exp_t e;
    e.q = q; e.rem = rem; e.dz = dz; e.to = to;
    sb.push_back(e);
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic s);
    int n;
    n = 0;
    in_a = a; in_d = d; in_signed = s; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 32'(n < 50), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_q"}, out_q, e.q);
      chk({tag, "_rem"}, out_rem, e.rem);
      chk({tag, "_dz"}, 32'(out_dz), 32'(e.dz));
      chk({tag, "_to"}, 32'(out_to), 32'(e.to));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int   starts0, dones0, n;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_d = '0; in_signed = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_out_q", out_q, 32'd0);
    chk("rst_flags", {30'd0, out_dz, out_to}, 32'd0);
    rst = 1'b0;

    // 100/3 with zero-latency divider: out_valid the cycle after div_done is sampled
    lat = 0;
    starts0 = start_cnt;
    send(32'd100, 32'd3, 1'b0);
    push(32'd33, 32'd1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("lat_done_seen", 32'(div_done), 32'd1);
    chk("lat_not_yet_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid_next", 32'(out_valid), 32'd1);
    get_result("u100_3");
    chk("u100_3_one_start", 32'(start_cnt - starts0), 32'd1);

    // Divide by zero: no start, valid right after acceptance
    starts0 = start_cnt;
    send(32'd1234, 32'd0, 1'b0);
    push(32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0);
    chk("dz_valid_next", 32'(out_valid), 32'd1);
    get_result("dz");
    chk("dz_no_start", 32'(start_cnt - starts0), 32'd0);

    // div_done on the last watchdog cycle wins; one cycle later it is a timeout
    lat = 6;
    send(32'd77, 32'd7, 1'b0);
    push(32'd11, 32'd0, 1'b0, 1'b0);
    get_result("done_at_limit");
    lat = 7;
    send(32'd77, 32'd7, 1'b0);
    push(32'd0, 32'd0, 1'b0, 1'b1);
    get_result("done_after_limit");

    // Divider never answers: exactly TO_CYC wait cycles then timeout
    never_done = 1'b1;
    starts0 = start_cnt;
    send(32'd50, 32'd5, 1'b0);
    seen = 1'b0;
    repeat (TO_CYC) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("to_not_early", 32'(seen), 32'd0);
    @(negedge clk);
    chk("to_valid_on_time", 32'(out_valid), 32'd1);
    push(32'd0, 32'd0, 1'b0, 1'b1);
    get_result("timeout");
    chk("to_one_start", 32'(start_cnt - starts0), 32'd1);
    never_done = 1'b0;

    // Back-pressure in HOLD with a new request pending
    lat = 1;
    send(32'd1000, 32'd10, 1'b0);
    push(32'd100, 32'd0, 1'b0, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    in_a = 32'd9; in_d = 32'd4; in_signed = 1'b0; in_valid = 1'b1;
    starts0 = start_cnt;
    repeat (5) begin
      chk("bp_q_stable", out_q, 32'd100);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk("bp_no_start", 32'(start_cnt - starts0), 32'd0);
    get_result("bp_first");
    chk("bp_ready_after_hs", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    push(32'd2, 32'd1, 1'b0, 1'b0);
    get_result("bp_second");

    // Reset mid-WAIT, late div_done must be ignored
    lat = 5;
    send(32'd300, 32'd7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_q", out_q, 32'd0);
    chk("mid_rst_out_rem", out_rem, 32'd0);
    chk("mid_rst_div_a", div_a, 32'd0);
    chk("mid_rst_div_d", div_d, 32'd0);
    dones0 = done_cnt;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("late_done_fired", 32'(done_cnt > dones0), 32'd1);
    chk("late_done_ignored", 32'(seen), 32'd0);
    lat = 2;
    send(32'd200, 32'd10, 1'b0);
    push(32'd20, 32'd0, 1'b0, 1'b0);
    get_result("after_rst");

    // Stray div_done while idle
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    chk("stray_done_idle", 32'(out_valid), 32'd0);

`ifdef DIV_SIGNED_EN
    lat = 1;
    send(32'hFFFF_FFF9, 32'd2, 1'b1);
    push(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    get_result("s_m7_2");
    send(32'd7, 32'hFFFF_FFFE, 1'b1);
    push(32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    get_result("s_7_m2");
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    push(32'h8000_0000, 32'd0, 1'b0, 1'b0);
    get_result("s_min_m1");
    send(32'hFFFF_FFFB, 32'd0, 1'b1);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0);
    get_result("s_dz");
`else
    lat = 1;
    send(32'hFFFF_FFF9, 32'd2, 1'b1);
    push(32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
    get_result("signed_ignored");
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, max cycles waited for div_done after div_start before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  sequencer can accept a request.
REQ-006 in_a  input  32  dividend.
REQ-007 in_d  input  32  divisor.
REQ-008 in_signed  input  1  request is signed; ignored unless DIV_SIGNED_EN is defined.
REQ-009 div_start  output  1  one-cycle start pulse to divider.
REQ-010 div_a / div_d  output  32 each  operands to divider; held stable from div_start through div_done.
REQ-011 div_r  input  64  divider result, {remainder[63:32], quotient[31:0]}, valid when div_done=1.
REQ-012 div_busy / div_done  input  1 each  divider status.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_q / out_rem  output  32 each  quotient / remainder.
REQ-016 out_dz / out_to  output  1 each  divide-by-zero flag / timeout flag.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, HOLD; only one request outstanding.
REQ-018 IDLE: in_ready=1; in_valid&in_ready latches in_a, in_d, in_signed; divisor 0 -> HOLD, else -> ISSUE.
REQ-019 ISSUE: div_start=1 for exactly one cycle, watchdog cleared; -> WAIT next cycle.
REQ-020 WAIT: watchdog increments each cycle; div_done=1 -> capture div_r (out_q=div_r[31:0], out_rem=div_r[63:32]), -> HOLD.
REQ-021 WAIT: watchdog reaching TIMEOUT_CYCLES without div_done -> out_q=0, out_rem=0, out_to=1, -> HOLD; div_done in that same cycle takes priority over timeout.
REQ-022 Divide-by-zero: divider never started; out_q=32'hFFFFFFFF, out_rem=latched dividend, out_dz=1.
REQ-023 HOLD: out_valid=1, outputs stable until out_valid&out_ready; then -> IDLE with out_dz/out_to cleared.
REQ-024 in_ready=0 in ISSUE, WAIT, HOLD; requests there are not accepted and must be held by the producer.
REQ-025 div_done outside WAIT is ignored.
REQ-026 Latency, non-zero divisor: out_valid rises 2 cycles after the div_done cycle's predecessor edge, i.e. the cycle after div_done is sampled; zero divisor: out_valid asserted the cycle after acceptance.
REQ-027 Back-to-back: earliest next acceptance is the cycle after the out handshake.

Reset
REQ-028 rst=1 at any clock edge, including mid-WAIT: state IDLE, in_ready=1 after release, div_start=0, out_valid=0, out_q=0, out_rem=0, out_dz=0, out_to=0, div_a=0, div_d=0, watchdog=0.
REQ-029 Result of a divide in flight at reset is discarded; a later stray div_done is ignored per REQ-025.

Configuration
REQ-030 Macro DIV_SIGNED_EN: when defined and in_signed=1, div_a/div_d carry operand magnitudes; out_q negated when operand signs differ; out_rem takes dividend sign.
REQ-031 Signed corner: -2^31 / -1 -> out_q=32'h80000000, out_rem=0 (wrap, no flag); signed divide-by-zero per REQ-022 (rem = signed dividend unchanged).
REQ-032 DIV_SIGNED_EN undefined: in_signed ignored, all requests unsigned, no sign logic synthesised.

Verification
REQ-033 100/3 unsigned with behavioural divider -> one div_start pulse, out_q=33, out_rem=1, flags 0.
REQ-034 in_d=0, in_a=1234 -> no div_start, next cycle out_valid, out_q=32'hFFFFFFFF, out_rem=1234, out_dz=1.
REQ-035 Divider model never asserts div_done, TIMEOUT_CYCLES=8 -> out_valid after 8 WAIT cycles, out_q=0, out_rem=0, out_to=1.
REQ-036 out_ready held 0 for 5 cycles in HOLD with new in_valid pending -> outputs stable, in_ready=0, request accepted only after handshake.
REQ-037 rst pulsed mid-WAIT then late div_done -> no out_valid, next request 200/10 returns 20 rem 0.
REQ-038 DIV_SIGNED_EN: -7/2 -> q=-3, rem=-1; 7/-2 -> q=-3, rem=1; 32'h80000000/-1 -> q=32'h80000000, rem=0.
